// File: rtl/fwd_pkg.sv
// fwd_pkg: shared select/state encodings and register-match helper for the forwarding/hazard controller.
package fwd_pkg;
    localparam int MAX_AW = 8;
    typedef enum logic [1:0] {
        FWD_RF    = 2'b00,
        FWD_EXMEM = 2'b10,
        FWD_MEMWB = 2'b01
    } fwd_sel_e;
    typedef enum logic [1:0] {
        HZ_RUN,
        HZ_LU_STALL,
        HZ_MEM_WAIT
    } hz_state_e;
    // Addresses are zero-extended to MAX_AW so one helper serves every AW.
    function automatic logic regMatch(
        input logic [MAX_AW-1:0] a,
        input logic [MAX_AW-1:0] d,
        input logic              we,
        input logic              zeroReg
    );
        return we && a == d && !(zeroReg && d == '0);
    endfunction
endpackage

// File: rtl/fwd_match_pick.sv
// fwd_match_pick: one source address against EX/MEM and MEM/WB destinations, EX/MEM winning.
module fwd_match_pick
    import fwd_pkg::*;
#(
    parameter int AW       = 4,
    parameter bit ZERO_REG = 1'b1
) (
    input  logic [AW-1:0] srcAddr,
    input  logic [AW-1:0] exmemDst,
    input  logic          exmemWe,
    input  logic [AW-1:0] memwbDst,
    input  logic          memwbWe,
    output logic [1:0]    sel
);
    fwd_sel_e pick;
    always_comb begin
        pick = regMatch(MAX_AW'(srcAddr), MAX_AW'(exmemDst), exmemWe, ZERO_REG) ? FWD_EXMEM :
               regMatch(MAX_AW'(srcAddr), MAX_AW'(memwbDst), memwbWe, ZERO_REG) ? FWD_MEMWB : FWD_RF;
    end
    assign sel = pick;
endmodule

// File: rtl/fwd_hazard_ctrl.sv
// fwd_hazard_ctrl: operand forwarding selects plus load-use stall, memory-wait freeze and stall counting.
module fwd_hazard_ctrl
    import fwd_pkg::*;
#(
    parameter int AW         = 4,
    parameter int NUM_SRC    = 2,
    parameter int LU_BUBBLES = 1,
    parameter int ZERO_REG   = 1,
    parameter int CNT_W      = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  id_valid,
    input  logic [NUM_SRC*AW-1:0] id_src_addr,
    input  logic [NUM_SRC-1:0]    id_src_used,
    input  logic [NUM_SRC*AW-1:0] idex_src_addr,
    input  logic [AW-1:0]         idex_dst_addr,
    input  logic                  idex_reg_write,
    input  logic                  idex_mem_read,
    input  logic [AW-1:0]         exmem_dst_addr,
    input  logic                  exmem_reg_write,
    input  logic [AW-1:0]         memwb_dst_addr,
    input  logic                  memwb_reg_write,
    input  logic                  mem_busy,
    input  logic                  flush,
    output logic [2*NUM_SRC-1:0]  fwd_sel,
    output logic [1:0]            fwd_dst_sel,
    output logic                  stall_if,
    output logic                  bubble_ex,
    output logic                  freeze_all,
    output logic                  lu_event,
    output logic [CNT_W-1:0]      stall_cnt
);
    localparam bit         ZR       = ZERO_REG != 0;
    localparam logic [2:0] BUB_INIT = LU_BUBBLES > 1 ? 3'(LU_BUBBLES - 2) : 3'd0;

    logic [(NUM_SRC+1)*AW-1:0] pickAddr;
    logic [2*NUM_SRC+1:0]      pickSel;
    hz_state_e                 state;
    logic [2:0]                bubCnt;
    logic                      retLu;
    logic                      luHit;
    logic                      luStart;
    logic                      stallRaw;

    // The EX destination rides along as an extra operand for LLB/LHB read-modify-write.
    assign pickAddr = {idex_dst_addr, idex_src_addr};
    for (genvar i = 0; i <= NUM_SRC; i++) begin : g_pick
        fwd_match_pick #(.AW(AW), .ZERO_REG(ZR)) u_pick (
            .srcAddr  (pickAddr[i*AW +: AW]),
            .exmemDst (exmem_dst_addr),
            .exmemWe  (exmem_reg_write),
            .memwbDst (memwb_dst_addr),
            .memwbWe  (memwb_reg_write),
            .sel      (pickSel[2*i +: 2])
        );
    end
    assign fwd_sel     = pickSel[2*NUM_SRC-1:0];
    assign fwd_dst_sel = pickSel[2*NUM_SRC +: 2];

    always_comb begin
        luHit = 1'b0;
        for (int k = 0; k < NUM_SRC; k++)
            luHit |= id_src_used[k] &&
                     regMatch(MAX_AW'(id_src_addr[k*AW +: AW]), MAX_AW'(idex_dst_addr), idex_reg_write, ZR);
        luHit &= id_valid && idex_mem_read;
    end

    // A memory wait state outranks everything; flush cancels any pending bubble.
    assign luStart    = state == HZ_RUN && !mem_busy && !flush && luHit;
    assign stallRaw   = !mem_busy && !flush && ((state == HZ_RUN && luHit) || state == HZ_LU_STALL);
    assign stall_if   = rst_n && stallRaw;
    assign bubble_ex  = stall_if;
    assign freeze_all = rst_n && mem_busy;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= HZ_RUN;
            bubCnt    <= 3'd0;
            retLu     <= 1'b0;
            lu_event  <= 1'b0;
            stall_cnt <= '0;
        end else begin
            lu_event <= luStart;
            if ((stall_if || freeze_all) && !(&stall_cnt))
                stall_cnt <= stall_cnt + 1'b1;
            case (state)
                HZ_RUN: begin
                    if (mem_busy) begin
                        state <= HZ_MEM_WAIT;
                        retLu <= 1'b0;
                    end else if (flush) begin
                        bubCnt <= 3'd0;
                        retLu  <= 1'b0;
                    end else if (luStart && LU_BUBBLES > 1) begin
                        state  <= HZ_LU_STALL;
                        bubCnt <= BUB_INIT;
                    end
                end
                HZ_LU_STALL: begin
                    if (mem_busy) begin
                        state <= HZ_MEM_WAIT;
                        retLu <= 1'b1;
                    end else if (flush) begin
                        state  <= HZ_RUN;
                        bubCnt <= 3'd0;
                        retLu  <= 1'b0;
                    end else if (bubCnt == 3'd0) begin
                        state <= HZ_RUN;
                    end else begin
                        bubCnt <= bubCnt - 3'd1;
                    end
                end
                HZ_MEM_WAIT: begin
                    if (!mem_busy)
                        state <= retLu ? HZ_LU_STALL : HZ_RUN;
                end
                default: state <= HZ_RUN;
            endcase
        end
    end
endmodule

// File: tb/tb_fwd_hazard_ctrl.sv
// tb_fwd_hazard_ctrl: directed and random checks of forwarding selects and stall/freeze behaviour.
module tb_fwd_hazard_ctrl;
    localparam int AW = 4;
    localparam int NS = 2;
    localparam int LB = 3;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic id_valid, idex_reg_write, idex_mem_read, exmem_reg_write, memwb_reg_write, mem_busy, flush;
    logic [NS*AW-1:0] id_src_addr, idex_src_addr;
    logic [NS-1:0] id_src_used;
    logic [AW-1:0] idex_dst_addr, exmem_dst_addr, memwb_dst_addr;
    logic [2*NS-1:0] fwd_sel, fwd_sel2;
    logic [1:0] fwd_dst_sel, fwd_dst_sel2;
    logic stall_if, bubble_ex, freeze_all, lu_event;
    logic stall_if2, bubble_ex2, freeze_all2, lu_event2;
    logic [15:0] stall_cnt;
    logic [1:0] sat_cnt;

    fwd_hazard_ctrl #(.AW(AW), .NUM_SRC(NS), .LU_BUBBLES(LB), .ZERO_REG(1), .CNT_W(16)) dut (
        .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_src_addr(id_src_addr),
        .id_src_used(id_src_used), .idex_src_addr(idex_src_addr), .idex_dst_addr(idex_dst_addr),
        .idex_reg_write(idex_reg_write), .idex_mem_read(idex_mem_read),
        .exmem_dst_addr(exmem_dst_addr), .exmem_reg_write(exmem_reg_write),
        .memwb_dst_addr(memwb_dst_addr), .memwb_reg_write(memwb_reg_write),
        .mem_busy(mem_busy), .flush(flush), .fwd_sel(fwd_sel), .fwd_dst_sel(fwd_dst_sel),
        .stall_if(stall_if), .bubble_ex(bubble_ex), .freeze_all(freeze_all),
        .lu_event(lu_event), .stall_cnt(stall_cnt)
    );

    fwd_hazard_ctrl #(.AW(AW), .NUM_SRC(NS), .LU_BUBBLES(LB), .ZERO_REG(1), .CNT_W(2)) dut_sat (
        .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_src_addr(id_src_addr),
        .id_src_used(id_src_used), .idex_src_addr(idex_src_addr), .idex_dst_addr(idex_dst_addr),
        .idex_reg_write(idex_reg_write), .idex_mem_read(idex_mem_read),
        .exmem_dst_addr(exmem_dst_addr), .exmem_reg_write(exmem_reg_write),
        .memwb_dst_addr(memwb_dst_addr), .memwb_reg_write(memwb_reg_write),
        .mem_busy(mem_busy), .flush(flush), .fwd_sel(fwd_sel2), .fwd_dst_sel(fwd_dst_sel2),
        .stall_if(stall_if2), .bubble_ex(bubble_ex2), .freeze_all(freeze_all2),
        .lu_event(lu_event2), .stall_cnt(sat_cnt)
    );

    always #5 clk = ~clk;

    int compared = 0;
    int mismatched = 0;
    int rem = 0;
    bit prevBusy = 1'b0;
    int cnt = 0;
    int nStall, nFreeze, nEvent;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] want);
        compared++;
        assert (obs === want) else begin
            mismatched++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, want);
        end
    endtask

    function automatic logic [1:0] refSel(input logic [AW-1:0] a);
        if (exmem_reg_write && a == exmem_dst_addr && a != 0) return 2'b10;
        if (memwb_reg_write && a == memwb_dst_addr && a != 0) return 2'b01;
        return 2'b00;
    endfunction

    function automatic bit refLuHit();
        bit h = 1'b0;
        for (int k = 0; k < NS; k++)
            if (id_src_used[k] && idex_reg_write && id_src_addr[k*AW +: AW] == idex_dst_addr && idex_dst_addr != 0)
                h = 1'b1;
        return id_valid && idex_mem_read && h;
    endfunction

    // Model: bubbles still owed, plus the dead cycle that follows a memory wait.
    task automatic cycle();
        bit wantStall = 1'b0;
        bit wantFreeze = 1'b0;
        bit start = 1'b0;
        #1;
        for (int k = 0; k < NS; k++)
            chk($sformatf("fwd_sel%0d", k), fwd_sel[2*k +: 2], refSel(idex_src_addr[k*AW +: AW]));
        chk("fwd_dst_sel", fwd_dst_sel, refSel(idex_dst_addr));
        if (rst_n) begin
            if (mem_busy) wantFreeze = 1'b1;
            else if (!prevBusy) begin
                if (flush) rem = 0;
                else if (rem > 0) begin wantStall = 1'b1; rem--; end
                else if (refLuHit()) begin wantStall = 1'b1; start = 1'b1; rem = LB - 1; end
            end
            prevBusy = mem_busy;
            if (wantStall || wantFreeze) cnt++;
        end else begin
            rem = 0;
            prevBusy = 1'b0;
            cnt = 0;
        end
        chk("stall_if", stall_if, wantStall);
        chk("bubble_ex", bubble_ex, wantStall);
        chk("freeze_all", freeze_all, wantFreeze);
        nStall += int'(stall_if);
        nFreeze += int'(freeze_all);
        @(posedge clk);
        #1;
        chk("lu_event", lu_event, start);
        chk("stall_cnt", stall_cnt, cnt > 65535 ? 65535 : cnt);
        chk("stall_cnt_sat", sat_cnt, cnt > 3 ? 3 : cnt);
        nEvent += int'(lu_event);
        @(negedge clk);
    endtask

    task automatic clearIn();
        id_valid = 0; id_src_addr = '0; id_src_used = '0; idex_src_addr = '0;
        idex_dst_addr = '0; idex_reg_write = 0; idex_mem_read = 0;
        exmem_dst_addr = '0; exmem_reg_write = 0; memwb_dst_addr = '0; memwb_reg_write = 0;
        mem_busy = 0; flush = 0;
    endtask

    task automatic rstPulse();
        clearIn();
        rst_n = 1'b0;
        cycle();
        rst_n = 1'b1;
        nStall = 0; nFreeze = 0; nEvent = 0;
    endtask

    task automatic loadUse();
        idex_dst_addr = 4'd3; idex_reg_write = 1; idex_mem_read = 1;
        id_valid = 1; id_src_addr = {4'd0, 4'd3}; id_src_used = 2'b01;
    endtask

    initial begin
        clearIn();
        nStall = 0; nFreeze = 0; nEvent = 0;
        cycle();
        chk("reset_cnt", stall_cnt, 0);
        rst_n = 1'b1;

        idex_src_addr = {4'd2, 4'd5};
        exmem_dst_addr = 4'd5; exmem_reg_write = 1; memwb_dst_addr = 4'd5; memwb_reg_write = 1;
        #1 chk("both_r5", fwd_sel[1:0], 2'b10);
        cycle();
        exmem_reg_write = 0;
        #1 chk("wb_r5", fwd_sel[1:0], 2'b01);
        cycle();

        exmem_dst_addr = 4'd0; exmem_reg_write = 1; memwb_reg_write = 0; idex_src_addr = '0;
        id_valid = 1; id_src_addr = '0; id_src_used = 2'b01;
        idex_dst_addr = 4'd0; idex_reg_write = 1; idex_mem_read = 1;
        #1 chk("zero_fwd", fwd_sel[1:0], 2'b00);
        chk("zero_lu", stall_if, 0);
        cycle();

        rstPulse();
        loadUse();
        cycle();
        idex_mem_read = 0;
        repeat (5) cycle();
        chk("lu_stalls", nStall, 3);
        chk("lu_events", nEvent, 1);
        chk("lu_cnt", stall_cnt, 3);

        rstPulse();
        loadUse();
        cycle();
        idex_mem_read = 0; mem_busy = 1;
        cycle();
        cycle();
        mem_busy = 0;
        repeat (5) cycle();
        chk("mw_stalls", nStall, 3);
        chk("mw_freezes", nFreeze, 2);
        chk("mw_cnt", stall_cnt, 5);
        chk("mw_sat", sat_cnt, 3);

        rstPulse();
        loadUse();
        flush = 1;
        cycle();
        flush = 0; idex_mem_read = 0;
        repeat (3) cycle();
        chk("flush_stalls", nStall, 0);
        chk("flush_events", nEvent, 0);

        rstPulse();
        loadUse();
        cycle();
        idex_mem_read = 0;
        cycle();
        rst_n = 1'b0;
        #1 chk("rst_stall", stall_if, 0);
        chk("rst_bubble", bubble_ex, 0);
        cycle();
        rst_n = 1'b1;
        nStall = 0;
        repeat (4) cycle();
        chk("rst_run", nStall, 0);

        repeat (400) begin
            id_valid = 1'($urandom);
            id_src_addr = {4'($urandom_range(0, 3)), 4'($urandom_range(0, 3))};
            id_src_used = 2'($urandom);
            idex_src_addr = {4'($urandom_range(0, 3)), 4'($urandom_range(0, 3))};
            idex_dst_addr = 4'($urandom_range(0, 3));
            idex_reg_write = 1'($urandom);
            idex_mem_read = 1'($urandom);
            exmem_dst_addr = 4'($urandom_range(0, 3));
            exmem_reg_write = 1'($urandom);
            memwb_dst_addr = 4'($urandom_range(0, 3));
            memwb_reg_write = 1'($urandom);
            mem_busy = $urandom_range(0, 7) == 0;
            flush = $urandom_range(0, 9) == 0;
            rst_n = $urandom_range(0, 99) != 0;
            cycle();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
